// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator and the detector benches.
package seq_pkg;

    // FSM state encoding; 2'd3 is unused and recovers to ST_IDLE.
    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_SHIFT = 2'd1;
    localparam seq_state_t ST_GAP   = 2'd2;

    // Default word width and inter-word gap.
    localparam int DEF_DW  = 8;
    localparam int DEF_GAP = 1;

endpackage

// File: rtl/seq_gen_tx_if.sv
// Word-in / bit-out bundle of the serial sequence transmitter.
interface seq_gen_tx_if #(
    parameter int DW = 8
);
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_seq;
    logic          o_seq_valid;
    logic          o_busy;
    logic          o_done;

    // Upstream word source / bit-stream consumer side.
    modport master (
        output i_valid, i_data,
        input  o_ready, o_seq, o_seq_valid, o_busy, o_done
    );

    // Transmitter side.
    modport slave (
        input  i_valid, i_data,
        output o_ready, o_seq, o_seq_valid, o_busy, o_done
    );
endinterface

// File: rtl/seq_gen_shreg.sv
// Loadable DW-bit shift register; shifts zeros in so it drains to all-zero.
module seq_gen_shreg #(
    parameter int DW        = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic          i_shift,
    input  logic [DW-1:0] i_data,
    output logic          o_head
);
    logic [DW-1:0] shreg_reg;
    logic [DW-1:0] shreg_next;
    logic [DW-1:0] shifted;

    // Shift one position toward the head bit, filling the tail with zero.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_bit
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_tail
                    assign shifted[gi] = 1'b0;
                end else begin : g_body
                    assign shifted[gi] = shreg_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == DW-1) begin : g_tail
                    assign shifted[gi] = 1'b0;
                end else begin : g_body
                    assign shifted[gi] = shreg_reg[gi+1];
                end
            end
        end
    endgenerate

    // Load has priority so a back-to-back word replaces the drained tail.
    always_comb begin
        shreg_next = shreg_reg;
        if (i_load) begin
            shreg_next = i_data;
        end else if (i_shift) begin
            shreg_next = shifted;
        end
    end

    // Register the shift state; reset aborts any word in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shreg_reg <= '0;
        end else begin
            shreg_reg <= shreg_next;
        end
    end

    assign o_head = MSB_FIRST ? shreg_reg[DW-1] : shreg_reg[0];

endmodule

// File: rtl/seq_gen_tx.sv
// Parallel-to-serial transmitter: one word per handshake, one bit per clock,
// followed by GAP idle zero bits.
module seq_gen_tx
    import seq_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int GAP       = DEF_GAP,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    seq_gen_tx_if.slave bus
);
    localparam int              CW       = $clog2(DW);
    localparam logic [CW-1:0]   BIT_LAST = CW'(DW - 1);
    localparam bit              HAS_GAP  = (GAP > 0);
    localparam logic [3:0]      GAP_LAST = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    seq_state_t    state_reg;
    seq_state_t    state_next;
    logic [CW-1:0] bit_cnt_reg;
    logic [3:0]    gap_cnt_reg;
    logic          accept;
    logic          bit_last;
    logic          gap_last;
    logic          head;

    assign bit_last = (bit_cnt_reg == BIT_LAST);
    assign gap_last = (gap_cnt_reg == GAP_LAST);
    assign accept   = bus.i_valid & bus.o_ready;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection; a new word can only arrive when o_ready is high.
    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE: begin
                state_next = accept ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                if (!bit_last) begin
                    state_next = ST_SHIFT;
                end else if (HAS_GAP) begin
                    state_next = ST_GAP;
                end else begin
                    state_next = accept ? ST_SHIFT : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!gap_last) begin
                    state_next = ST_GAP;
                end else begin
                    state_next = accept ? ST_SHIFT : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs, decoded from registered state only.
    always_comb begin
        bus.o_seq_valid = (state_reg == ST_SHIFT);
        bus.o_busy      = (state_reg == ST_SHIFT) || (state_reg == ST_GAP);
        bus.o_done      = (state_reg == ST_SHIFT) && bit_last;
        bus.o_ready     = (state_reg == ST_IDLE)
                        || ((state_reg == ST_SHIFT) && bit_last && !HAS_GAP)
                        || ((state_reg == ST_GAP) && gap_last && HAS_GAP);
    end

    // Bit and gap counters; both restart exactly at their terminal values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else begin
            if (accept) begin
                bit_cnt_reg <= '0;
            end else if (state_reg == ST_SHIFT) begin
                bit_cnt_reg <= bit_last ? '0 : bit_cnt_reg + CW'(1);
            end

            if ((state_reg == ST_SHIFT) && bit_last) begin
                gap_cnt_reg <= '0;
            end else if (state_reg == ST_GAP) begin
                gap_cnt_reg <= gap_last ? 4'd0 : gap_cnt_reg + 4'd1;
            end
        end
    end

    // The shift register drains to zero after DW shifts, so its head bit is
    // already 0 in GAP and IDLE and can drive o_seq directly.
    seq_gen_shreg #(
        .DW        (DW),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (accept),
        .i_shift (state_reg == ST_SHIFT),
        .i_data  (bus.i_data),
        .o_head  (head)
    );

    assign bus.o_seq = head;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed bench for seq_gen_tx: four configurations share one clock and reset.
module tb_seq_gen_tx;
    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    seq_gen_tx_if #(.DW(8)) if_msb ();
    seq_gen_tx_if #(.DW(8)) if_lsb ();
    seq_gen_tx_if #(.DW(8)) if_b2b ();
    seq_gen_tx_if #(.DW(8)) if_gap3 ();

    seq_gen_tx #(.DW(8), .GAP(1), .MSB_FIRST(1'b1)) u_msb (
        .i_clk (clk), .i_rst (rst), .bus (if_msb)
    );
    seq_gen_tx #(.DW(8), .GAP(1), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk (clk), .i_rst (rst), .bus (if_lsb)
    );
    seq_gen_tx #(.DW(8), .GAP(0), .MSB_FIRST(1'b1)) u_b2b (
        .i_clk (clk), .i_rst (rst), .bus (if_b2b)
    );
    seq_gen_tx #(.DW(8), .GAP(3), .MSB_FIRST(1'b1)) u_gap3 (
        .i_clk (clk), .i_rst (rst), .bus (if_gap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] w1;
        logic [7:0] w2;
        logic       eb;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        if_msb.i_valid  = 1'b1; if_msb.i_data  = 8'hFF;
        if_lsb.i_valid  = 1'b1; if_lsb.i_data  = 8'hFF;
        if_b2b.i_valid  = 1'b1; if_b2b.i_data  = 8'hFF;
        if_gap3.i_valid = 1'b1; if_gap3.i_data = 8'hFF;

        // Reset held three cycles with valid high: nothing may be accepted.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", {31'd0, if_msb.o_ready}, 32'd1);
            check("rst_seq",   {31'd0, if_msb.o_seq},   32'd0);
            check("rst_busy",  {31'd0, if_msb.o_busy},  32'd0);
            check("rst_done",  {31'd0, if_msb.o_done},  32'd0);
        end
        if_msb.i_valid = 1'b0; if_lsb.i_valid = 1'b0;
        if_b2b.i_valid = 1'b0; if_gap3.i_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_no_accept_msb", {31'd0, if_msb.o_busy},  32'd0);
        check("rst_no_accept_b2b", {31'd0, if_b2b.o_busy},  32'd0);
        $display("tx reset: done");

        // Single word, MSB first, one gap bit.
        w1 = 8'hB4;
        if_msb.i_valid = 1'b1; if_msb.i_data = w1;
        tick();
        if_msb.i_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            check("msb_seq",   {31'd0, if_msb.o_seq},       {31'd0, w1[7-n]});
            check("msb_sv",    {31'd0, if_msb.o_seq_valid}, 32'd1);
            check("msb_done",  {31'd0, if_msb.o_done},      {31'd0, (n == 7)});
            check("msb_ready", {31'd0, if_msb.o_ready},     32'd0);
            tick();
        end
        check("msb_gap_seq",   {31'd0, if_msb.o_seq},       32'd0);
        check("msb_gap_sv",    {31'd0, if_msb.o_seq_valid}, 32'd0);
        check("msb_gap_busy",  {31'd0, if_msb.o_busy},      32'd1);
        check("msb_gap_ready", {31'd0, if_msb.o_ready},     32'd1);
        tick();
        check("msb_idle_busy",  {31'd0, if_msb.o_busy},  32'd0);
        check("msb_idle_ready", {31'd0, if_msb.o_ready}, 32'd1);
        $display("tx msb_first word=%h", w1);

        // Single word, LSB first.
        w1 = 8'h0D;
        if_lsb.i_valid = 1'b1; if_lsb.i_data = w1;
        tick();
        if_lsb.i_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            check("lsb_seq",  {31'd0, if_lsb.o_seq},       {31'd0, w1[n]});
            check("lsb_sv",   {31'd0, if_lsb.o_seq_valid}, 32'd1);
            tick();
        end
        check("lsb_gap_seq", {31'd0, if_lsb.o_seq},       32'd0);
        check("lsb_gap_sv",  {31'd0, if_lsb.o_seq_valid}, 32'd0);
        tick();
        check("lsb_idle_busy", {31'd0, if_lsb.o_busy}, 32'd0);
        $display("tx lsb_first word=%h", w1);

        // Back-to-back streaming with no gap.
        w1 = 8'hAA;
        w2 = 8'h55;
        if_b2b.i_valid = 1'b1; if_b2b.i_data = w1;
        tick();
        if_b2b.i_data = w2;
        for (int c = 1; c <= 16; c++) begin
            eb = (c <= 8) ? w1[8-c] : w2[16-c];
            check("b2b_seq",   {31'd0, if_b2b.o_seq},       {31'd0, eb});
            check("b2b_sv",    {31'd0, if_b2b.o_seq_valid}, 32'd1);
            check("b2b_ready", {31'd0, if_b2b.o_ready},     {31'd0, (c == 8 || c == 16)});
            check("b2b_done",  {31'd0, if_b2b.o_done},      {31'd0, (c == 8 || c == 16)});
            if (c == 16) if_b2b.i_valid = 1'b0;
            tick();
        end
        check("b2b_end_sv",   {31'd0, if_b2b.o_seq_valid}, 32'd0);
        check("b2b_end_busy", {31'd0, if_b2b.o_busy},      32'd0);
        $display("tx back_to_back words=%h,%h", w1, w2);

        // Three-bit gap with valid held high: period of 11 cycles.
        w1 = 8'hC3;
        w2 = 8'h3C;
        if_gap3.i_valid = 1'b1; if_gap3.i_data = w1;
        tick();
        if_gap3.i_data = w2;
        for (int c = 1; c <= 19; c++) begin
            if (c <= 8)       eb = w1[8-c];
            else if (c >= 12) eb = w2[19-c];
            else              eb = 1'b0;
            check("gap3_seq",   {31'd0, if_gap3.o_seq},       {31'd0, eb});
            check("gap3_sv",    {31'd0, if_gap3.o_seq_valid}, {31'd0, (c <= 8 || c >= 12)});
            check("gap3_busy",  {31'd0, if_gap3.o_busy},      32'd1);
            check("gap3_ready", {31'd0, if_gap3.o_ready},     {31'd0, (c == 11)});
            if (c == 12) if_gap3.i_valid = 1'b0;
            tick();
        end
        for (int c = 20; c <= 22; c++) begin
            check("gap3_tail_seq",   {31'd0, if_gap3.o_seq},   32'd0);
            check("gap3_tail_ready", {31'd0, if_gap3.o_ready}, {31'd0, (c == 22)});
            tick();
        end
        check("gap3_idle_busy", {31'd0, if_gap3.o_busy}, 32'd0);
        $display("tx gap3 words=%h,%h", w1, w2);

        // Reset in the middle of a word aborts it asynchronously.
        w1 = 8'hFF;
        if_msb.i_valid = 1'b1; if_msb.i_data = w1;
        tick();
        if_msb.i_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("abort_pre_seq", {31'd0, if_msb.o_seq}, 32'd1);
            if (n < 3) tick();
        end
        rst = 1'b1;
        #1;
        check("abort_seq",  {31'd0, if_msb.o_seq},       32'd0);
        check("abort_busy", {31'd0, if_msb.o_busy},      32'd0);
        check("abort_sv",   {31'd0, if_msb.o_seq_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("abort_idle_busy",  {31'd0, if_msb.o_busy},  32'd0);
        check("abort_idle_ready", {31'd0, if_msb.o_ready}, 32'd1);
        $display("tx abort word=%h", w1);

        w1 = 8'h81;
        if_msb.i_valid = 1'b1; if_msb.i_data = w1;
        tick();
        if_msb.i_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            check("post_seq", {31'd0, if_msb.o_seq},       {31'd0, w1[7-n]});
            check("post_sv",  {31'd0, if_msb.o_seq_valid}, 32'd1);
            tick();
        end
        check("post_gap_seq", {31'd0, if_msb.o_seq}, 32'd0);
        $display("tx post_reset word=%h", w1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
